udp_tx_sched: RTL

UDP_TX_SCHED -- requirements
Module: udp_tx_sched

---
 rtl/udp_tx_sched_if.sv | 44 ++++
 rtl/udp_tx_sched.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/udp_tx_sched_if.sv
// Sender-side bundle of the UDP line-packet scheduler.
// timeout_err exists only when UDP_TX_TIMEOUT_EN is defined.
interface udp_tx_sched_if;
  logic        frame_sync;
  logic [11:0] v_height;
  logic [10:0] fifo_rd_count;
  logic [3:0]  tx_state;
  logic        frame_sync_o;
  logic        line_sync_o;
  logic [15:0] line_number;
  logic [15:0] tx_data_length;
  logic [15:0] tx_total_length;
  logic        busy;
  logic        frame_done;
`ifdef UDP_TX_TIMEOUT_EN
  logic        timeout_err;

  modport master (
    input  frame_sync, v_height, fifo_rd_count, tx_state,
    output frame_sync_o, line_sync_o, line_number,
    output tx_data_length, tx_total_length,
    output busy, frame_done, timeout_err
  );
  modport slave (
    output frame_sync, v_height, fifo_rd_count, tx_state,
    input  frame_sync_o, line_sync_o, line_number,
    input  tx_data_length, tx_total_length,
    input  busy, frame_done, timeout_err
  );
`else
  modport master (
    input  frame_sync, v_height, fifo_rd_count, tx_state,
    output frame_sync_o, line_sync_o, line_number,
    output tx_data_length, tx_total_length,
    output busy, frame_done
  );
  modport slave (
    output frame_sync, v_height, fifo_rd_count, tx_state,
    input  frame_sync_o, line_sync_o, line_number,
    input  tx_data_length, tx_total_length,
    input  busy, frame_done
  );
`endif
endinterface

// File: rtl/udp_tx_sched.sv
// Paces one UDP packet per video line into the IP frame sender.
// Optional FIFO-fill watchdog enabled by macro UDP_TX_TIMEOUT_EN.
module udp_tx_sched #(
  parameter int         PAYLOAD_WORDS  = 320,
  parameter int         IPG_CYCLES     = 16,
  parameter logic [3:0] TX_IDLE        = 4'd0,
  parameter int         TIMEOUT_CYCLES = 1000000
) (
  input logic            g_clk,
  input logic            reset,
  udp_tx_sched_if.master bus
);
  typedef enum logic [2:0] {
    IDLE, WAIT_DATA, START, SEND, GAP
  } state_t;

  localparam logic [10:0] THR = 11'(PAYLOAD_WORDS);
  localparam logic [7:0]  IPG = 8'(IPG_CYCLES);

  state_t      state, state_n;
  logic [15:0] line_cnt, line_cnt_n;
  logic [11:0] h_lat, h_lat_n;
  logic [7:0]  gap_cnt, gap_cnt_n;
  logic        pend, pend_n;
  logic        seen, seen_n;
  logic        ls_n, fs_n, fd_n;
  logic [15:0] ln_n;
  logic        fifo_ok, last, sync_req;
`ifdef UDP_TX_TIMEOUT_EN
  localparam logic [31:0] TO_LIM = 32'(TIMEOUT_CYCLES - 1);
  logic [31:0] to_cnt, to_cnt_n;
  logic        to_err_n;
`endif

  assign fifo_ok  = bus.fifo_rd_count >= THR;
  assign last     = line_cnt == {4'd0, h_lat};
  assign sync_req = pend || bus.frame_sync;
  assign bus.busy = state != IDLE;
  assign bus.tx_data_length  = 16'(PAYLOAD_WORDS * 4 + 8);
  assign bus.tx_total_length = 16'(PAYLOAD_WORDS * 4 + 28);

  always_comb begin
    state_n    = state;
    line_cnt_n = line_cnt;
    h_lat_n    = h_lat;
    gap_cnt_n  = gap_cnt;
    pend_n     = pend;
    seen_n     = seen;
    ls_n       = 1'b0;
    fs_n       = 1'b0;
    fd_n       = 1'b0;
    ln_n       = bus.line_number;
`ifdef UDP_TX_TIMEOUT_EN
    to_cnt_n   = '0;
    to_err_n   = 1'b0;
`endif
    if (bus.frame_sync && state != IDLE)
      pend_n = 1'b1;
    unique case (state)
      IDLE: begin
        if (bus.frame_sync) begin
          h_lat_n    = bus.v_height;
          line_cnt_n = '0;
          if (bus.v_height == '0) fd_n = 1'b1;
          else state_n = WAIT_DATA;
        end
      end
      WAIT_DATA: begin
        if (fifo_ok) state_n = START;
`ifdef UDP_TX_TIMEOUT_EN
        else if (to_cnt == TO_LIM) begin
          line_cnt_n = line_cnt + 16'd1;
          to_err_n   = 1'b1;
          gap_cnt_n  = IPG;
          state_n    = GAP;
        end else to_cnt_n = to_cnt + 32'd1;
`endif
      end
      START: begin
        ls_n    = 1'b1;
        ln_n    = line_cnt;
        fs_n    = line_cnt == '0;
        seen_n  = 1'b0;
        state_n = SEND;
      end
      SEND: begin
        if (bus.tx_state != TX_IDLE) seen_n = 1'b1;
        else if (seen) begin
          gap_cnt_n = IPG;
          state_n   = GAP;
          // a queued frame_sync truncates the frame here
          if (sync_req) begin
            fd_n       = 1'b1;
            line_cnt_n = '0;
            h_lat_n    = bus.v_height;
            pend_n     = 1'b0;
          end else line_cnt_n = line_cnt + 16'd1;
        end
      end
      GAP: begin
        if (gap_cnt > 8'd1) gap_cnt_n = gap_cnt - 8'd1;
        else begin
          gap_cnt_n = '0;
          if (!last) state_n = WAIT_DATA;
          else begin
            fd_n = 1'b1;
            if (sync_req) begin
              h_lat_n    = bus.v_height;
              line_cnt_n = '0;
              pend_n     = 1'b0;
              state_n    = (bus.v_height == '0) ? IDLE : WAIT_DATA;
            end else state_n = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge g_clk) begin
    if (reset) begin
      state            <= IDLE;
      line_cnt         <= '0;
      h_lat            <= '0;
      gap_cnt          <= '0;
      pend             <= 1'b0;
      seen             <= 1'b0;
      bus.line_sync_o  <= 1'b0;
      bus.frame_sync_o <= 1'b0;
      bus.frame_done   <= 1'b0;
      bus.line_number  <= '0;
    end else begin
      state            <= state_n;
      line_cnt         <= line_cnt_n;
      h_lat            <= h_lat_n;
      gap_cnt          <= gap_cnt_n;
      pend             <= pend_n;
      seen             <= seen_n;
      bus.line_sync_o  <= ls_n;
      bus.frame_sync_o <= fs_n;
      bus.frame_done   <= fd_n;
      bus.line_number  <= ln_n;
    end
  end

`ifdef UDP_TX_TIMEOUT_EN
  always_ff @(posedge g_clk) begin
    if (reset) begin
      to_cnt          <= '0;
      bus.timeout_err <= 1'b0;
    end else begin
      to_cnt          <= to_cnt_n;
      bus.timeout_err <= to_err_n;
    end
  end
`endif
endmodule
